// File: rtl/positadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : positadd_arbiter
// Purpose  : Shares one pipelined posit adder among NREQ requesters. Grants
//            are round-robin, issues are registered, and results are routed
//            back to the owner through a LATENCY-deep tag shift register.
//            Supports a drain handshake and a sticky tag/done desync flag.
// Options  : POSITADD_ARB_PRIO0_EN - requester 0 gets strict priority and the
//            other requesters share round-robin among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module positadd_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*32-1:0]     req_in1,
  input  logic [NREQ*32-1:0]     req_in2,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [31:0]            rsp_result,
  output logic                   rsp_inf,
  output logic                   rsp_zero,
  output logic                   add_start,
  output logic [31:0]            add_in1,
  output logic [31:0]            add_in2,
  input  logic [31:0]            add_result,
  input  logic                   add_inf,
  input  logic                   add_zero,
  input  logic                   add_done,
  input  logic                   drain_req,
  output logic                   drain_ack,
  output logic [3:0]             inflight,
  output logic                   err_desync
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   last;        // index of the last accepted requester
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [NREQ-1:0] grant_vec;
  logic [IW-1:0]   issue_idx;   // owner of the operation on the issue port
  int              cand;

  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_idx [LATENCY];
  logic               tail_v;
  logic [IW-1:0]      tail_idx;
  logic [3:0]         inflight_nxt;

  assign tail_v    = tag_v[LATENCY-1];
  assign tail_idx  = tag_idx[LATENCY-1];
  assign req_ready = grant_vec;
  assign drain_ack = (state == ST_DRAINED);

  // Grant selection: at most one valid requester, only while running and not draining.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    if (rst_n && state == ST_RUN && !drain_req) begin
`ifdef POSITADD_ARB_PRIO0_EN
      if (req_valid[0]) begin
        grant_any = 1'b1;
      end else begin
        // Rotate over 1..NREQ-1 only; last never holds 0 in this mode.
        for (int k = 1; k < NREQ; k++) begin
          cand = 1 + ((int'(last) - 1 + k) % (NREQ - 1));
          if (!grant_any && req_valid[IW'(cand)]) begin
            grant_any = 1'b1;
            grant_idx = IW'(cand);
          end
        end
      end
`else
      for (int k = 1; k <= NREQ; k++) begin
        cand = (int'(last) + k) % NREQ;
        if (!grant_any && req_valid[IW'(cand)]) begin
          grant_any = 1'b1;
          grant_idx = IW'(cand);
        end
      end
`endif
      if (grant_any) grant_vec = NREQ'(1) << grant_idx;
    end
  end

  // Issue register and round-robin pointer, both updated on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_start <= 1'b0;
      add_in1   <= '0;
      add_in2   <= '0;
      issue_idx <= '0;
      last      <= IW'(NREQ - 1);
    end else begin
      add_start <= grant_any;
      if (grant_any) begin
        add_in1   <= req_in1[grant_idx*32 +: 32];
        add_in2   <= req_in2[grant_idx*32 +: 32];
        issue_idx <= grant_idx;
`ifdef POSITADD_ARB_PRIO0_EN
        if (grant_idx != '0) last <= grant_idx;
`else
        last <= grant_idx;
`endif
      end
    end
  end

  // Tag pipeline mirrors the adder: head loaded from the issue port, shifted every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      tag_v[0]   <= add_start;
      tag_idx[0] <= issue_idx;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Route a tagged result to its owner; shared bus reads zero when nobody is addressed.
  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_inf    = 1'b0;
    rsp_zero   = 1'b0;
    if (add_done && tail_v) begin
      rsp_valid  = NREQ'(1) << tail_idx;
      rsp_result = add_result;
      rsp_inf    = add_inf;
      rsp_zero   = add_zero;
    end
  end

  // An op leaves the count when its tag leaves the tail, so a lost done cannot wedge a drain.
  assign inflight_nxt = inflight + 4'(add_start) - 4'(tail_v);

  // Occupancy counter and sticky desync detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= '0;
      err_desync <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (add_done != tail_v) err_desync <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next-state: the drained test looks at next-cycle occupancy so drain_ack
  // rises in the cycle right after the final response.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (drain_req) state_nxt = ST_DRAINING;
      ST_DRAINING: if (inflight_nxt == 4'd0 && !add_start) state_nxt = ST_DRAINED;
      ST_DRAINED:  if (!drain_req) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_positadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_positadd_arbiter
// Purpose  : Self-checking bench for positadd_arbiter with a behavioural
//            adder and a queue-based reference of grants and responses.
//            Honours POSITADD_ARB_PRIO0_EN in its arbitration reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_positadd_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_in1;
  logic [NREQ*32-1:0]  req_in2;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_result;
  logic                rsp_inf, rsp_zero;
  logic                add_start;
  logic [31:0]         add_in1, add_in2;
  logic [31:0]         add_result;
  logic                add_inf, add_zero, add_done;
  logic                drain_req = 1'b0;
  logic                drain_ack;
  logic [3:0]          inflight;
  logic                err_desync;

  logic [31:0] op1 [NREQ];
  logic [31:0] op2 [NREQ];
  logic        force_done = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rr_last = NREQ - 1;

  positadd_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
    .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero),
    .add_done(add_done),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .inflight(inflight), .err_desync(err_desync)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_in1[32*g +: 32] = op1[g];
    assign req_in2[32*g +: 32] = op2[g];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: 1.0 + 1.0 gives posit 2.0, anything else a simple sum.
  function automatic logic [31:0] fres(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
    return a + b;
  endfunction
  function automatic logic finf(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h8000_0000) || (b == 32'h8000_0000);
  endfunction
  function automatic logic fzero(input logic [31:0] a, input logic [31:0] b);
    return fres(a, b) == 32'h0;
  endfunction
  function automatic logic [31:0] new_op();
    if ($urandom_range(0, 7) == 0) return 32'h8000_0000;
    return $urandom();
  endfunction

  // Reference arbitration: first valid requester after 'last' in circular order.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    int c;
`ifdef POSITADD_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
`ifdef POSITADD_ARB_PRIO0_EN
      if (c == 0) continue;
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction
  function automatic int rr_next(input int last, input int g);
`ifdef POSITADD_ARB_PRIO0_EN
    if (g == 0) return last;
`endif
    return g;
  endfunction

  typedef struct {int due; logic [31:0] res; logic inf; logic zero;} mop_t;
  mop_t mq[$];

  // Adder model: returns each issue LAT cycles later; reset together with the DUT.
  initial begin
    add_done = 1'b0; add_result = '0; add_inf = 1'b0; add_zero = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        add_done = 1'b1; add_result = mq[0].res; add_inf = mq[0].inf; add_zero = mq[0].zero;
        void'(mq.pop_front());
      end else if (force_done) begin
        add_done = 1'b1; add_result = 32'hDEAD_BEEF; add_inf = 1'b1; add_zero = 1'b1;
      end else begin
        add_done = 1'b0; add_result = '0; add_inf = 1'b0; add_zero = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (add_start)
        mq.push_back('{cyc + LAT, fres(add_in1, add_in2), finf(add_in1, add_in2), fzero(add_in1, add_in2)});
    end
  end

  typedef struct {int acc; int idx; logic [31:0] res; logic inf; logic zero;} exp_t;
  exp_t eq[$];

  task automatic test_reset();
    req_valid = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, add_start, add_in1, add_in2, drain_ack, inflight, err_desync} !== '0)
      begin errors++; $display("FAIL reset_outputs got ready=%b rsp=%b start=%b in1=%h in2=%h ack=%b infl=%0d err=%b exp all 0",
        req_ready, rsp_valid, add_start, add_in1, add_in2, drain_ack, inflight, err_desync); end
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1; rr_last = NREQ - 1;
  endtask

  task automatic test_single();
    int t0;
    @(posedge clk); #1;
    op1[2] = 32'h4000_0000; op2[2] = 32'h4000_0000; req_valid = 4'b0100;
    @(negedge clk); t0 = cyc;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
    @(posedge clk); #1; req_valid = '0; rr_last = rr_next(rr_last, 2);
    @(negedge clk);
    checks++;
    if (add_start !== 1'b1 || add_in1 !== 32'h4000_0000 || add_in2 !== 32'h4000_0000)
      begin errors++; $display("FAIL single_issue got start=%b in1=%h in2=%h exp 1/40000000/40000000", add_start, add_in1, add_in2); end
    for (int c = t0 + 2; c <= t0 + LAT + 3; c++) begin
      @(negedge clk);
      if (c == t0 + 2) begin
        checks++;
        if (inflight !== 4'd1) begin errors++; $display("FAIL single_inflight got=%0d exp=1", inflight); end
      end
      checks++;
      if (c == t0 + LAT + 1) begin
        if (rsp_valid !== 4'b0100 || rsp_result !== 32'h4800_0000 || rsp_inf !== 1'b0 || rsp_zero !== 1'b0)
          begin errors++; $display("FAIL single_rsp cyc=%0d got v=%b r=%h exp v=0100 r=48000000", c - t0, rsp_valid, rsp_result); end
      end else if (rsp_valid !== '0 || rsp_result !== '0) begin
        errors++; $display("FAIL single_idle cyc=%0d got v=%b r=%h exp 0", c - t0, rsp_valid, rsp_result);
      end
    end
    checks++;
    if (inflight !== 4'd0) begin errors++; $display("FAIL single_inflight_end got=%0d exp=0", inflight); end
  endtask

  // Traffic with the reference queue; optional drain window [d_on, d_off].
  task automatic test_traffic(input string name, input int ncyc, input bit all_valid,
                              input logic [NREQ-1:0] allow, input int d_on, input int d_off,
                              input bit want_peak);
    int g, pg = -1, n, peak = 0;
    bit pacc = 1'b0, dwin, e_ack;
    logic [31:0] pa = '0, pb = '0, e_r;
    logic [NREQ-1:0] e_rdy, e_v;
    logic e_i, e_z;
    eq.delete();
    for (int t = 0; t < ncyc + LAT + 4; t++) begin
      @(posedge clk); #1;
      if (pacc) begin req_valid[pg] = 1'b0; op1[pg] = new_op(); op2[pg] = new_op(); end
      dwin = (d_on >= 0) && (t >= d_on) && (t <= d_off);
      drain_req = (d_on >= 0) && (t >= d_on) && (t < d_off);
      for (int i = 0; i < NREQ; i++)
        if (t >= ncyc || !allow[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && (all_valid || $urandom_range(0, 1) == 1)) req_valid[i] = 1'b1;
      @(negedge clk);
      g = dwin ? -1 : rr_pick(req_valid, rr_last);
      e_rdy = (g < 0) ? '0 : NREQ'(1) << g;
      checks++;
      if (req_ready !== e_rdy) begin errors++; $display("FAIL %s_grant t=%0d got=%b exp=%b", name, t, req_ready, e_rdy); end
      checks++;
      if (add_start !== pacc || (pacc && (add_in1 !== pa || add_in2 !== pb)))
        begin errors++; $display("FAIL %s_issue t=%0d got start=%b in1=%h in2=%h exp %b %h %h", name, t, add_start, add_in1, add_in2, pacc, pa, pb); end
      n = 0;
      foreach (eq[k]) if (eq[k].acc + 2 <= cyc) n++;
      checks++;
      if (inflight !== 4'(n)) begin errors++; $display("FAIL %s_inflight t=%0d got=%0d exp=%0d", name, t, inflight, n); end
      if (int'(inflight) > peak) peak = int'(inflight);
      e_ack = (d_on >= 0) && (t >= d_on + 2) && (t <= d_off) && (eq.size() == 0);
      checks++;
      if (drain_ack !== e_ack) begin errors++; $display("FAIL %s_ack t=%0d got=%b exp=%b", name, t, drain_ack, e_ack); end
      e_v = '0; e_r = '0; e_i = 1'b0; e_z = 1'b0;
      if (eq.size() > 0 && eq[0].acc + LAT + 1 == cyc) begin
        e_v = NREQ'(1) << eq[0].idx; e_r = eq[0].res; e_i = eq[0].inf; e_z = eq[0].zero;
        void'(eq.pop_front());
      end
      checks++;
      if (rsp_valid !== e_v || rsp_result !== e_r || rsp_inf !== e_i || rsp_zero !== e_z)
        begin errors++; $display("FAIL %s_rsp t=%0d got v=%b r=%h i=%b z=%b exp v=%b r=%h i=%b z=%b",
          name, t, rsp_valid, rsp_result, rsp_inf, rsp_zero, e_v, e_r, e_i, e_z); end
      pacc = (g >= 0); pg = g;
      if (pacc) begin
        pa = op1[g]; pb = op2[g];
        eq.push_back('{cyc, g, fres(pa, pb), finf(pa, pb), fzero(pa, pb)});
        rr_last = rr_next(rr_last, g);
      end
    end
    drain_req = 1'b0;
    checks++;
    if (inflight !== 4'd0 || err_desync !== 1'b0)
      begin errors++; $display("FAIL %s_end got infl=%0d err=%b exp 0 0", name, inflight, err_desync); end
    if (want_peak) begin
      checks++;
      if (peak != LAT) begin errors++; $display("FAIL %s_peak got=%0d exp=%0d", name, peak, LAT); end
    end
  endtask

  task automatic test_reset_inflight();
    int g;
    @(posedge clk); #1; req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      g = rr_pick(req_valid, rr_last);
      checks++;
      if (req_ready !== NREQ'(1) << g) begin errors++; $display("FAIL rstfl_grant k=%0d got=%b exp=%0d", k, req_ready, g); end
      rr_last = rr_next(rr_last, g);
    end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (inflight !== 4'd3) begin errors++; $display("FAIL rstfl_pre got=%0d exp=3", inflight); end
    rst_n = 1'b0; req_valid = '1; #1;
    checks++;
    if ({req_ready, rsp_valid, add_start, add_in1, add_in2, drain_ack, inflight, err_desync} !== '0)
      begin errors++; $display("FAIL rstfl_async got ready=%b start=%b infl=%0d exp all 0", req_ready, add_start, inflight); end
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1; rr_last = NREQ - 1;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || err_desync !== 1'b0 || inflight !== 4'd0)
        begin errors++; $display("FAIL rstfl_after k=%0d got rsp=%b err=%b infl=%0d exp 0", k, rsp_valid, err_desync, inflight); end
    end
  endtask

  task automatic test_desync();
    @(posedge clk); #1; force_done = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || rsp_result !== '0 || rsp_inf !== 1'b0 || rsp_zero !== 1'b0)
      begin errors++; $display("FAIL desync_rsp got v=%b r=%h exp 0", rsp_valid, rsp_result); end
    @(posedge clk); #1; force_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (err_desync !== 1'b1 || rsp_valid !== '0)
        begin errors++; $display("FAIL desync_sticky k=%0d got err=%b rsp=%b exp 1 0", k, err_desync, rsp_valid); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin op1[i] = new_op(); op2[i] = new_op(); end
    test_reset();
    test_single();
    test_traffic("b2b", 40, 1'b1, 4'b1111, -1, -1, 1'b1);
    test_traffic("rand", 200, 1'b0, 4'b1111, -1, -1, 1'b0);
    test_traffic("no0", 30, 1'b1, 4'b1110, -1, -1, 1'b0);
    test_traffic("drain", 27, 1'b1, 4'b1111, 5, 25, 1'b0);
    test_reset_inflight();
    test_desync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/positadd_arbiter.md
POSITADD_ARBITER -- requirements
Module: positadd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one posit adder (2..8).
REQ-002 SHALL have parameter LATENCY, default 8, add_start-to-add_done delay of the adder in cycles.
REQ-003 SHALL have ports, one per line:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  grant; a request is accepted when valid and ready are both high.
- req_in1  input  NREQ*32  operand A per requester; slice i is [32i+31:32i].
- req_in2  input  NREQ*32  operand B per requester.
- rsp_valid  output  NREQ  one-hot result strobe to the owning requester.
- rsp_result  output  32  shared result bus.
- rsp_inf, rsp_zero  output  1 each  shared flag outputs.
- add_start, add_in1[32], add_in2[32]  output  issue port to the adder.
- add_result[32], add_inf, add_zero, add_done  input  adder return port.
- drain_req  input  1  stop issuing and empty the pipeline.
- drain_ack  output  1  pipeline empty while draining.
- inflight  output  4  operations issued but not yet returned.
- err_desync  output  1  sticky tag/done mismatch flag.

Function
REQ-004 SHALL assert at most one req_ready bit per cycle, and only in state RUN.
REQ-005 SHALL choose the grant round-robin: search starts at the index after the last accepted requester, wrapping NREQ-1 to 0; the pointer advances only on acceptance.
REQ-006 SHALL register the accepted operands on the accepting edge: add_start is high for exactly one cycle, the cycle after acceptance.
REQ-007 SHALL accept back-to-back requests, one per cycle, with no bubbles.
REQ-008 SHALL keep a LATENCY-deep tag shift register of {valid, index}, loaded when add_start is high and shifted every cycle.
REQ-009 SHALL, when add_done is high and the tail tag is valid:
- assert rsp_valid[tail index] for that cycle only;
- drive rsp_result, rsp_inf and rsp_zero combinationally from the adder.
REQ-010 SHALL hold rsp_valid low at all other times, and drive rsp_result, rsp_inf and rsp_zero to 0 whenever rsp_valid is all zero.
REQ-011 SHALL produce end-to-end latency of exactly LATENCY+1 cycles from acceptance to rsp_valid.
REQ-012 SHALL set err_desync when add_done differs from the tail tag valid bit; it is sticky until reset, and no rsp_valid is generated for an untagged done.
REQ-013 SHALL maintain inflight as issues minus returns, updated per cycle; a simultaneous issue and return leaves it unchanged; its maximum is LATENCY.
REQ-014 SHALL implement states RUN, DRAINING and DRAINED:
- RUN -> DRAINING when drain_req is high; no new grants from that cycle on.
- DRAINING -> DRAINED when inflight == 0 and no add_start is pending.
- DRAINED -> RUN when drain_req goes low.
REQ-015 SHALL assert drain_ack exactly while in DRAINED.
REQ-016 SHALL ignore req_valid of non-granted requesters; requesters keep their operands stable until accepted.

Reset
REQ-017 SHALL on rst_n low immediately:
- clear all outputs to 0 (req_ready, rsp_valid, add_start, add_in1, add_in2, drain_ack, inflight, err_desync);
- clear all tag valid bits;
- set the round-robin pointer so requester 0 has first priority;
- enter state RUN.
REQ-018 SHALL discard results of operations in flight at reset; add_done pulses arriving after reset while tags are empty set err_desync only if the adder itself was not reset.

Configuration
REQ-019 SHALL, with POSITADD_ARB_PRIO0_EN defined, give requester 0 strict priority over all others; the remaining requesters are round-robin among themselves.
REQ-020 SHALL, without POSITADD_ARB_PRIO0_EN, use pure round-robin over all NREQ requesters.

Verification
REQ-021 SHALL cover these directed scenarios:
- Single op: req 2 sends 0x40000000 + 0x40000000, accepted at cycle T -> rsp_valid[2] at T+9 with the adder's result; inflight returns to 0.
- All four requesters valid continuously, macro off -> grants 0,1,2,3,0,... one per cycle; responses in the same order 9 cycles later.
- Macro on, all four valid -> requester 0 granted every cycle; with req 0 idle, 1,2,3 rotate.
- drain_req asserted with 5 ops in flight -> no grants; drain_ack rises in the cycle after the last rsp_valid; drain_req low -> RUN again.
- rst_n pulsed low with 3 ops in flight -> outputs 0 immediately; no rsp_valid after release (adder also reset); err_desync stays 0.
- Forced add_done with no valid tail tag -> err_desync = 1, stays 1, no rsp_valid.
